// File: rtl/ib_pingpong_sched.sv
// Ping-pong scheduler for two single-port input-buffer banks: the packer fills one
// bank while the reader drains the other, with frames read in fill order.
module ib_pingpong_sched #(
    parameter int DEPTH = 29,
    parameter int AW    = 5,
    parameter int DW    = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_we,
    input  logic [DW-1:0] wr_din,
    output logic          wr_ready,
    output logic          rd_start,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd_done,
    output logic          rd_sel,
    output logic [1:0]    bank_en,
    output logic [1:0]    bank_we,
    output logic [AW-1:0] bank_addr0,
    output logic [AW-1:0] bank_addr1,
    output logic [DW-1:0] bank_din,
    output logic [1:0]    full,
    output logic          err
);

    typedef enum logic [1:0] {
        S_FREE,
        S_FILLING,
        S_FULL,
        S_READING
    } bank_state_t;

    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

    bank_state_t   state [2];
    logic          wb;
    logic          rb;
    logic [AW-1:0] wcnt;

    logic reading;
    logic wr_acc;
    logic rd_acc;
    logic rd_fin;

    // Only the bank at rb can ever be READING, so that one test covers both banks.
    assign reading  = (state[rb] == S_READING);
    assign wr_ready = (state[wb] == S_FREE) || (state[wb] == S_FILLING);
    assign wr_acc   = wr_we & wr_ready;
    assign rd_acc   = rd_en & reading & ({1'b0, rd_addr} < DEPTH_W);
    assign rd_fin   = rd_done & reading;

    assign full[0] = (state[0] == S_FULL) || (state[0] == S_READING);
    assign full[1] = (state[1] == S_FULL) || (state[1] == S_READING);

    always_ff @(posedge clk) begin
        if (rst) begin
            state[0]   <= S_FREE;
            state[1]   <= S_FREE;
            wb         <= 1'b0;
            rb         <= 1'b0;
            wcnt       <= '0;
            rd_start   <= 1'b0;
            rd_sel     <= 1'b0;
            bank_en    <= 2'b00;
            bank_we    <= 2'b00;
            bank_addr0 <= '0;
            bank_addr1 <= '0;
            bank_din   <= '0;
            err        <= 1'b0;
        end else begin
            bank_en  <= 2'b00;
            bank_we  <= 2'b00;
            rd_start <= 1'b0;

            // Writer and reader always target different banks, so both may fire.
            if (wr_acc) begin
                bank_en[wb] <= 1'b1;
                bank_we[wb] <= 1'b1;
                if (wb) bank_addr1 <= wcnt;
                else    bank_addr0 <= wcnt;
                bank_din <= wr_din;
                if (wcnt == LAST) begin
                    wcnt      <= '0;
                    state[wb] <= S_FULL;
                    wb        <= ~wb;
                end else begin
                    wcnt      <= wcnt + 1'b1;
                    state[wb] <= S_FILLING;
                end
            end

            if (rd_acc) begin
                bank_en[rb] <= 1'b1;
                if (rb) bank_addr1 <= rd_addr;
                else    bank_addr0 <= rd_addr;
            end

            if (rd_fin) begin
                state[rb] <= S_FREE;
                rb        <= ~rb;
            end else if (!reading && state[rb] == S_FULL) begin
                rd_start  <= 1'b1;
                state[rb] <= S_READING;
                rd_sel    <= rb;
            end

            if ((wr_we && !wr_ready) || (rd_en && !rd_acc) || (rd_done && !reading))
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ib_pingpong_sched.sv
// Bench for ib_pingpong_sched: scoreboarded RAM writes, hand sequences for the
// ping-pong corners, and a vector table for reader protocol errors.
module tb_ib_pingpong_sched;

    localparam int DEPTH = 29;
    localparam int AW    = 5;
    localparam int DW    = 256;
    localparam int W     = 1 + AW + 32;

    logic          clk;
    logic          rst;
    logic          wr_we;
    logic [DW-1:0] wr_din;
    logic          wr_ready;
    logic          rd_start;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_done;
    logic          rd_sel;
    logic [1:0]    bank_en;
    logic [1:0]    bank_we;
    logic [AW-1:0] bank_addr0;
    logic [AW-1:0] bank_addr1;
    logic [DW-1:0] bank_din;
    logic [1:0]    full;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected RAM writes: {bank, addr, data word}
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic          ren;
        logic [AW-1:0] raddr;
        logic          done;
        logic [1:0]    en;
        logic [1:0]    full;
        logic          start;
        logic          err;
        logic [AW-1:0] addr0;
    } vec_t;

    vec_t vecs [6];

    ib_pingpong_sched #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_we      (wr_we),
        .wr_din     (wr_din),
        .wr_ready   (wr_ready),
        .rd_start   (rd_start),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_done    (rd_done),
        .rd_sel     (rd_sel),
        .bank_en    (bank_en),
        .bank_we    (bank_we),
        .bank_addr0 (bank_addr0),
        .bank_addr1 (bank_addr1),
        .bank_din   (bank_din),
        .full       (full),
        .err        (err)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        wr_we   = 1'b0;
        wr_din  = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        rd_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic idle();
        wr_we   = 1'b0;
        rd_en   = 1'b0;
        rd_done = 1'b0;
        tick();
    endtask

    // Accepted write expected at (bnk, a); optionally with rd_done on the same edge.
    task automatic wr(input logic bnk, input int a, input logic with_done);
        logic [31:0] d;
        d       = $urandom_range(32'hFFFF_FFFE, 0);
        wr_din  = {8{d}};
        wr_we   = 1'b1;
        rd_done = with_done;
        exp_q.push_back({bnk, AW'(a), d});
        tick();
        wr_we   = 1'b0;
        rd_done = 1'b0;
    endtask

    // Scoreboard: every RAM write must match the next expected one.
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] act;
        if (bank_we != 2'b00) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: bank_we=%b addr0=%0d addr1=%0d, none expected",
                         bank_we, bank_addr0, bank_addr1);
            end else begin
                e   = exp_q.pop_front();
                act = {bank_we[1], bank_we[1] ? bank_addr1 : bank_addr0, bank_din[31:0]};
                check("write_access", 64'(act), 64'(e));
                check("write_din_hi", 64'(bank_din[DW-1 -: 32]), 64'(e[31:0]));
                check("write_en", 64'(bank_en & bank_we), 64'(bank_we));
            end
        end
    end

    initial begin
        vecs[0] = '{ren: 1'b1, raddr: AW'(29), done: 1'b0, en: 2'b00, full: 2'b01, start: 1'b0, err: 1'b1, addr0: AW'(28)};
        vecs[1] = '{ren: 1'b1, raddr: AW'(28), done: 1'b0, en: 2'b01, full: 2'b01, start: 1'b0, err: 1'b1, addr0: AW'(28)};
        vecs[2] = '{ren: 1'b1, raddr: AW'(0),  done: 1'b0, en: 2'b01, full: 2'b01, start: 1'b0, err: 1'b1, addr0: AW'(0)};
        vecs[3] = '{ren: 1'b0, raddr: AW'(0),  done: 1'b1, en: 2'b00, full: 2'b00, start: 1'b0, err: 1'b1, addr0: AW'(0)};
        vecs[4] = '{ren: 1'b0, raddr: AW'(0),  done: 1'b1, en: 2'b00, full: 2'b00, start: 1'b0, err: 1'b1, addr0: AW'(0)};
        vecs[5] = '{ren: 1'b1, raddr: AW'(3),  done: 1'b0, en: 2'b00, full: 2'b00, start: 1'b0, err: 1'b1, addr0: AW'(0)};

        // Reset state
        do_reset();
        check("rst_wr_ready", 64'(wr_ready), 64'(1));
        check("rst_full", 64'(full), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_rd_start", 64'(rd_start), 64'(0));
        check("rst_rd_sel", 64'(rd_sel), 64'(0));
        check("rst_bank_en", 64'(bank_en), 64'(0));
        check("rst_bank_we", 64'(bank_we), 64'(0));
        check("rst_addr0", 64'(bank_addr0), 64'(0));
        check("rst_addr1", 64'(bank_addr1), 64'(0));
        check("rst_din", 64'(bank_din[63:0]), 64'(0));

        // Fill bank0; start pulse one cycle after FULL
        for (int i = 0; i < DEPTH; i++) begin
            wr(1'b0, i, 1'b0);
            if (i == DEPTH - 2) check("fill0_not_full_yet", 64'(full), 64'(2'b00));
        end
        check("fill0_full", 64'(full), 64'(2'b01));
        check("fill0_no_early_start", 64'(rd_start), 64'(0));
        check("fill0_wr_ready", 64'(wr_ready), 64'(1));
        idle();
        check("start0_pulse", 64'(rd_start), 64'(1));
        check("start0_sel", 64'(rd_sel), 64'(0));
        check("start0_full", 64'(full), 64'(2'b01));
        idle();
        check("start0_one_cycle", 64'(rd_start), 64'(0));

        // Fill bank1 while bank0 is being read
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 3) begin
                rd_en   = 1'b1;
                rd_addr = AW'(5);
            end
            wr(1'b1, i, 1'b0);
            if (i == 3) begin
                rd_en = 1'b0;
                check("concur_bank_en", 64'(bank_en), 64'(2'b11));
                check("concur_bank_we", 64'(bank_we), 64'(2'b10));
                check("concur_addr0", 64'(bank_addr0), 64'(5));
            end
        end
        check("both_full", 64'(full), 64'(2'b11));
        check("both_full_not_ready", 64'(wr_ready), 64'(0));
        check("both_full_err_clear", 64'(err), 64'(0));
        wr_din = {8{32'hDEAD_BEEF}};
        wr_we  = 1'b1;
        tick();
        wr_we = 1'b0;
        check("drop_err", 64'(err), 64'(1));
        check("drop_no_we", 64'(bank_we), 64'(2'b00));
        check("drop_full", 64'(full), 64'(2'b11));

        // Release bank0, bank1 starts next cycle
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        check("done0_full", 64'(full), 64'(2'b10));
        check("done0_wr_ready", 64'(wr_ready), 64'(1));
        check("done0_no_start", 64'(rd_start), 64'(0));
        idle();
        check("start1_pulse", 64'(rd_start), 64'(1));
        check("start1_sel", 64'(rd_sel), 64'(1));
        idle();

        // Last write into bank0 with rd_done on bank1
        for (int i = 0; i < DEPTH; i++) wr(1'b0, i, i == DEPTH - 1);
        check("simA_full", 64'(full), 64'(2'b01));
        check("simA_wr_ready", 64'(wr_ready), 64'(1));
        check("simA_no_start", 64'(rd_start), 64'(0));
        wr(1'b1, 0, 1'b0);
        check("simA_start", 64'(rd_start), 64'(1));
        check("simA_sel", 64'(rd_sel), 64'(0));
        check("simA_we", 64'(bank_we), 64'(2'b10));

        // Last write into bank1 with rd_done on bank0
        for (int i = 1; i < DEPTH; i++) wr(1'b1, i, i == DEPTH - 1);
        check("simB_full", 64'(full), 64'(2'b10));
        check("simB_wr_ready", 64'(wr_ready), 64'(1));
        wr(1'b0, 0, 1'b0);
        check("simB_start", 64'(rd_start), 64'(1));
        check("simB_sel", 64'(rd_sel), 64'(1));
        check("err_sticky", 64'(err), 64'(1));

        // rd_done with nothing READING
        do_reset();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        check("early_done_err", 64'(err), 64'(1));
        check("early_done_full", 64'(full), 64'(2'b00));
        check("early_done_wr_ready", 64'(wr_ready), 64'(1));
        check("early_done_no_start", 64'(rd_start), 64'(0));
        wr(1'b0, 0, 1'b0);
        check("early_done_fill", 64'(full), 64'(2'b00));

        // Reader protocol vectors on a READING bank0
        do_reset();
        for (int i = 0; i < DEPTH; i++) wr(1'b0, i, 1'b0);
        idle();
        check("vec_pre_start", 64'(rd_start), 64'(1));
        check("vec_pre_err", 64'(err), 64'(0));
        for (int k = 0; k < 6; k++) begin
            rd_en   = vecs[k].ren;
            rd_addr = vecs[k].raddr;
            rd_done = vecs[k].done;
            tick();
            rd_en   = 1'b0;
            rd_done = 1'b0;
            check($sformatf("vec%0d_en", k), 64'(bank_en), 64'(vecs[k].en));
            check($sformatf("vec%0d_we", k), 64'(bank_we), 64'(0));
            check($sformatf("vec%0d_full", k), 64'(full), 64'(vecs[k].full));
            check($sformatf("vec%0d_start", k), 64'(rd_start), 64'(vecs[k].start));
            check($sformatf("vec%0d_err", k), 64'(err), 64'(vecs[k].err));
            check($sformatf("vec%0d_addr0", k), 64'(bank_addr0), 64'(vecs[k].addr0));
        end

        // Reset mid-frame discards the partial frame and clears err
        do_reset();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        for (int i = 0; i < 10; i++) wr(1'b0, i, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_full", 64'(full), 64'(0));
        check("midrst_wr_ready", 64'(wr_ready), 64'(1));
        check("midrst_err", 64'(err), 64'(0));
        check("midrst_we", 64'(bank_we), 64'(0));
        for (int i = 0; i < DEPTH - 1; i++) wr(1'b0, i, 1'b0);
        check("midrst_not_full", 64'(full), 64'(2'b00));
        wr(1'b0, DEPTH - 1, 1'b0);
        check("midrst_full_at_depth", 64'(full), 64'(2'b01));
        idle();
        check("midrst_start", 64'(rd_start), 64'(1));
        check("midrst_sel", 64'(rd_sel), 64'(0));

        idle();
        idle();
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
